// File: rtl/cpu_cache_top_if.sv
// Bus bundle for cpu_cache_top: 32-bit CPU request port plus the 256-bit physical memory port.
// The cache uses the slave view; the requester/memory side uses the master view.
interface cpu_cache_top_if;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [31:0]  mem_wdata;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_rdata, mem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_rdata, mem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/cpu_cache_top.sv
// Two-way set-associative write-back/write-allocate cache: 8 sets, 32-byte lines, 1-bit LRU per set.
// Tag and data arrays sit under the datapath instance so they can be probed by hierarchical path.

module cache_array #(parameter int WIDTH = 24) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [2:0]       idx_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] data [8];

   // NOTE: contents must read as zero after reset, so this is a flop array with an async clear, not a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) data[i] <= '0;
      end else if (we_i) begin
         data[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = data[idx_i];
endmodule

module cache_datapath (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         access_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [31:0]  wdata_i,
   input  logic [3:0]   be_i,
   input  logic         fill_i,
   input  logic         wb_done_i,
   input  logic [255:0] fill_data_i,
   output logic         hit_o,
   output logic [31:0]  rdata_o,
   output logic         victim_dirty_o,
   output logic [23:0]  victim_tag_o,
   output logic [255:0] victim_line_o
);
   logic [23:0]  tag, tag0, tag1;
   logic [2:0]   set, word;
   logic [255:0] line0, line1, hit_line, merged, line_wdata;
   logic         hit0, hit1, victim, fill0, fill1, wr0, wr1;
   logic [7:0]   valid0_q, valid0_d, valid1_q, valid1_d;
   logic [7:0]   dirty0_q, dirty0_d, dirty1_q, dirty1_d;
   logic [7:0]   lru_q, lru_d;
   logic         unused_addr_bits;

   assign tag  = addr_i[31:8];
   assign set  = addr_i[7:5];
   assign word = addr_i[4:2];
   assign unused_addr_bits = ^addr_i[1:0];

   cache_array #(.WIDTH(24))  tag_array0  (.clk, .rst_n, .we_i(fill0), .idx_i(set), .wdata_i(tag), .rdata_o(tag0));
   cache_array #(.WIDTH(24))  tag_array1  (.clk, .rst_n, .we_i(fill1), .idx_i(set), .wdata_i(tag), .rdata_o(tag1));
   cache_array #(.WIDTH(256)) data_array0 (.clk, .rst_n, .we_i(fill0 | wr0), .idx_i(set),
                                           .wdata_i(line_wdata), .rdata_o(line0));
   cache_array #(.WIDTH(256)) data_array1 (.clk, .rst_n, .we_i(fill1 | wr1), .idx_i(set),
                                           .wdata_i(line_wdata), .rdata_o(line1));

   assign hit0     = access_i & valid0_q[set] & (tag0 == tag);
   assign hit1     = access_i & valid1_q[set] & (tag1 == tag);
   assign hit_o    = hit0 | hit1;
   assign hit_line = hit1 ? line1 : line0;
   assign rdata_o  = hit_o ? hit_line[32*word +: 32] : '0;
   assign wr0      = hit0 & write_i;
   assign wr1      = hit1 & write_i;

   // Victim: first invalid way, else the LRU way. Stable for the whole miss since
   // valid and lru only change on the fill edge.
   assign victim         = !valid0_q[set] ? 1'b0 : (!valid1_q[set] ? 1'b1 : lru_q[set]);
   assign fill0          = fill_i & ~victim;
   assign fill1          = fill_i & victim;
   assign victim_tag_o   = victim ? tag1 : tag0;
   assign victim_line_o  = victim ? line1 : line0;
   assign victim_dirty_o = victim ? (valid1_q[set] & dirty1_q[set]) : (valid0_q[set] & dirty0_q[set]);

   // NOTE: combinational blocks use blocking '=' and assign a default first, so no path infers a latch.
   always_comb begin
      merged = hit_line;
      for (int b = 0; b < 4; b++) begin
         if (be_i[b]) merged[32*word + 8*b +: 8] = wdata_i[8*b +: 8];
      end
   end

   assign line_wdata = fill_i ? fill_data_i : merged;

   always_comb begin
      valid0_d = valid0_q;
      valid1_d = valid1_q;
      dirty0_d = dirty0_q;
      dirty1_d = dirty1_q;
      lru_d    = lru_q;
      if (fill0) begin
         valid0_d[set] = 1'b1;
         dirty0_d[set] = 1'b0;
      end
      if (fill1) begin
         valid1_d[set] = 1'b1;
         dirty1_d[set] = 1'b0;
      end
      if (wb_done_i) begin
         if (victim) dirty1_d[set] = 1'b0;
         else        dirty0_d[set] = 1'b0;
      end
      if (wr0) dirty0_d[set] = 1'b1;
      if (wr1) dirty1_d[set] = 1'b1;
      if (hit_o) lru_d[set] = hit0;
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid0_q <= '0;
         valid1_q <= '0;
         dirty0_q <= '0;
         dirty1_q <= '0;
         lru_q    <= '0;
      end else begin
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         dirty0_q <= dirty0_d;
         dirty1_q <= dirty1_d;
         lru_q    <= lru_d;
      end
   end
endmodule

module cpu_cache_top (
   input  logic           clk,
   input  logic           rst_n,
   cpu_cache_top_if.slave bus
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] FILL      = 2'd2;

   logic [1:0]   state_q, state_d;
   logic         request, hit, victim_dirty;
   logic [23:0]  victim_tag;
   logic [255:0] victim_line;

   assign request = bus.mem_read | bus.mem_write;

   cache_datapath datapath (
      .clk,
      .rst_n,
      .access_i      (request && (state_q == IDLE)),
      .write_i       (bus.mem_write),
      .addr_i        (bus.mem_address),
      .wdata_i       (bus.mem_wdata),
      .be_i          (bus.mem_byte_enable),
      .fill_i        ((state_q == FILL) && bus.pmem_resp),
      .wb_done_i     ((state_q == WRITEBACK) && bus.pmem_resp),
      .fill_data_i   (bus.pmem_rdata),
      .hit_o         (hit),
      .rdata_o       (bus.mem_rdata),
      .victim_dirty_o(victim_dirty),
      .victim_tag_o  (victim_tag),
      .victim_line_o (victim_line)
   );

   assign bus.mem_resp = hit;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (request && !hit) state_d = victim_dirty ? WRITEBACK : FILL;
         WRITEBACK: if (bus.pmem_resp) state_d = FILL;
         FILL:      if (bus.pmem_resp) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Memory-side outputs decode straight from state, so reset drops them asynchronously.
   always_comb begin
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      case (state_q)
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {victim_tag, bus.mem_address[7:5], 5'b0};
            bus.pmem_wdata   = victim_line;
         end
         FILL: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {bus.mem_address[31:5], 5'b0};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cpu_cache_top.sv
// Self-checking bench for cpu_cache_top: directed vector table, multi-cycle corner sequences,
// and randomized accesses scored against a word-level memory model with a 2-entry recency list per set.
`timescale 1ns/1ps
module tb_cpu_cache_top;
   logic clk;
   logic rst_n;
   cpu_cache_top_if bus ();
   cpu_cache_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          exp_fills;
      int          exp_wbs;
      logic [31:0] exp_wb_addr;
      bit          chk_rdata;
      logic [31:0] exp_rdata;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   logic [255:0] mem_m [logic [26:0]];
   logic [31:0]  ref_m [logic [29:0]];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Untouched memory holds byte_address ^ 0xC0DE0000 in every word.
   function automatic logic [255:0] mem_line(input logic [31:0] a);
      logic [255:0] l;
      if (mem_m.exists(a[31:5])) return mem_m[a[31:5]];
      for (int i = 0; i < 8; i++) l[32*i +: 32] = {a[31:5], 3'(i), 2'b00} ^ 32'hC0DE_0000;
      return l;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_m.exists(a[31:2])) return ref_m[a[31:2]];
      return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
   endfunction

   task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = ref_rd(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_m[a[31:2]] = w;
   endtask

   task automatic idle_inputs();
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_address = '0;
      bus.mem_wdata = '0;
      bus.mem_byte_enable = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mem_m.delete();
      ref_m.delete();
   endtask

   task automatic serve_pmem(output bit is_wr, output logic [31:0] a, output logic [255:0] wd);
      bit stable;
      int lat;
      stable = 1'b1;
      lat = $urandom_range(0, 3);
      is_wr = bus.pmem_write;
      a = bus.pmem_address;
      wd = bus.pmem_wdata;
      check("pmem_exclusive", bus.pmem_read & bus.pmem_write, 0);
      check("pmem_addr_align", a[4:0], 0);
      repeat (lat) begin
         @(negedge clk);
         if (bus.pmem_address !== a || bus.pmem_write !== is_wr || bus.pmem_read !== !is_wr ||
             bus.mem_resp !== 1'b0 || (is_wr && bus.pmem_wdata !== wd)) stable = 1'b0;
      end
      check("pmem_stable", stable, 1);
      if (is_wr) mem_m[a[31:5]] = wd;
      else bus.pmem_rdata = mem_line(a);
      bus.pmem_resp = 1'b1;
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      bus.pmem_rdata = '0;
   endtask

   // Called just after a rising edge; returns just after the edge that completes the access.
   task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output int fills, output int wbs,
                         output logic [31:0] wb_addr, output logic [255:0] wb_data);
      bit done, is_wr;
      logic [31:0] a;
      logic [255:0] wd;
      done = 1'b0; fills = 0; wbs = 0; wb_addr = '0; wb_data = '0; rdata = '0;
      bus.mem_read = rd;
      bus.mem_write = wr;
      bus.mem_address = addr;
      bus.mem_wdata = wdata;
      bus.mem_byte_enable = be;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (bus.mem_resp) begin
            rdata = bus.mem_rdata;
            done = 1'b1;
            check("resp_no_pmem", bus.pmem_read | bus.pmem_write, 0);
         end else if (bus.pmem_read || bus.pmem_write) begin
            serve_pmem(is_wr, a, wd);
            if (is_wr) begin
               wbs++;
               wb_addr = a;
               wb_data = wd;
            end else begin
               fills++;
            end
         end
      end
      check("access_completed", done, 1);
      if (done) begin
         @(posedge clk);
         #1;
      end
      idle_inputs();
   endtask

   function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int f, input int w, input logic [31:0] wa,
                               input bit chk, input logic [31:0] rdat);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
      v.exp_fills = f; v.exp_wbs = w; v.exp_wb_addr = wa; v.chk_rdata = chk; v.exp_rdata = rdat;
      return v;
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [16];
      logic [31:0] rdata, wb_addr, addr, exp_rdata, exp_wb_addr;
      logic [255:0] wb_data, exp_line, exp_wb_data;
      int fills, wbs;
      bit seen, rd, wr, exp_hit, exp_wb;
      logic [23:0] mru_t [8];
      logic [23:0] lru_t [8];
      logic [23:0] tag, victim;
      int cnt [8];
      bit dirty_m [logic [26:0]];
      logic [2:0] s;
      logic [3:0] be;
      logic [31:0] wd;
      int op;

      // rd, wr, addr, wdata, be, fills, wbs, wb_addr, check rdata, rdata
      vecs[0]  = mk(1, 0, 32'h060, 0, 0, 1, 0, 0, 1, 32'hC0DE0060);
      vecs[1]  = mk(1, 0, 32'h064, 0, 0, 0, 0, 0, 1, 32'hC0DE0064);
      vecs[2]  = mk(0, 1, 32'h060, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 0, 32'h060, 0, 0, 0, 0, 0, 1, 32'hC0DEBEEF);
      vecs[4]  = mk(1, 0, 32'h160, 0, 0, 1, 0, 0, 1, 32'hC0DE0160);
      vecs[5]  = mk(1, 0, 32'h260, 0, 0, 1, 1, 32'h060, 1, 32'hC0DE0260);
      vecs[6]  = mk(1, 0, 32'h000, 0, 0, 1, 0, 0, 1, 32'hC0DE0000);
      vecs[7]  = mk(1, 0, 32'h100, 0, 0, 1, 0, 0, 1, 32'hC0DE0100);
      vecs[8]  = mk(1, 0, 32'h000, 0, 0, 0, 0, 0, 1, 32'hC0DE0000);
      vecs[9]  = mk(1, 0, 32'h200, 0, 0, 1, 0, 0, 1, 32'hC0DE0200);
      vecs[10] = mk(1, 0, 32'h000, 0, 0, 0, 0, 0, 1, 32'hC0DE0000);
      vecs[11] = mk(1, 0, 32'h100, 0, 0, 1, 0, 0, 1, 32'hC0DE0100);
      vecs[12] = mk(0, 1, 32'h304, 32'h12345678, 4'hF, 1, 0, 0, 0, 0);
      vecs[13] = mk(1, 0, 32'h304, 0, 0, 0, 0, 0, 1, 32'h12345678);
      vecs[14] = mk(1, 1, 32'h308, 32'hAABBCCDD, 4'b1100, 0, 0, 0, 0, 0);
      vecs[15] = mk(1, 0, 32'h308, 0, 0, 0, 0, 0, 1, 32'hAABB0308);

      // Reset state
      apply_reset();
      @(negedge clk);
      check("reset_mem_resp", bus.mem_resp, 0);
      check("reset_pmem_read", bus.pmem_read, 0);
      check("reset_pmem_write", bus.pmem_write, 0);
      check("reset_pmem_address", bus.pmem_address, 0);
      check("reset_pmem_wdata", bus.pmem_wdata, 0);
      check("reset_tag0_3", dut.datapath.tag_array0.data[3], 0);
      check("reset_data1_7", dut.datapath.data_array1.data[7], 0);
      @(posedge clk);
      #1;

      // Directed vector table
      for (int i = 0; i < 16; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdata, fills, wbs, wb_addr, wb_data);
         check($sformatf("v%0d_fills", i), fills, vecs[i].exp_fills);
         check($sformatf("v%0d_wbs", i), wbs, vecs[i].exp_wbs);
         if (vecs[i].exp_wbs != 0) check($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].exp_wb_addr);
         if (vecs[i].chk_rdata) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
         if (i == 0) begin
            check("v0_tag0_3", dut.datapath.tag_array0.data[3], 0);
            check("v0_data0_3", dut.datapath.data_array0.data[3], mem_line(32'h060));
         end
         if (i == 2) check("v2_merged_word", dut.datapath.data_array0.data[3][31:0], 32'hC0DEBEEF);
         if (i == 5) begin
            exp_line = mem_line(32'h1060);
            for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = {27'h3, 3'(k), 2'b00} ^ 32'hC0DE_0000;
            exp_line[31:0] = 32'hC0DEBEEF;
            check("v5_wb_data", wb_data, exp_line);
            check("v5_wb_line_index", wb_addr >> 5, 3);
         end
         if (i == 9) check("v9_way1_replaced", dut.datapath.tag_array1.data[0], 24'h2);
      end

      // Write miss: fill then merge, line left dirty, later evicted with the merged word
      apply_reset();
      access(0, 1, 32'h104, 32'hCAFEF00D, 4'hF, rdata, fills, wbs, wb_addr, wb_data);
      check("wmiss_fills", fills, 1);
      check("wmiss_wbs", wbs, 0);
      @(negedge clk);
      check("wmiss_single_resp", bus.mem_resp, 0);
      check("wmiss_tag", dut.datapath.tag_array0.data[0], 24'h1);
      check("wmiss_word1", dut.datapath.data_array0.data[0][63:32], 32'hCAFEF00D);
      @(posedge clk);
      #1;
      access(1, 0, 32'h200, 0, 0, rdata, fills, wbs, wb_addr, wb_data);
      access(1, 0, 32'h300, 0, 0, rdata, fills, wbs, wb_addr, wb_data);
      check("wmiss_evict_wbs", wbs, 1);
      check("wmiss_evict_addr", wb_addr, 32'h100);
      check("wmiss_evict_word1", wb_data[63:32], 32'hCAFEF00D);
      check("wmiss_evict_word0", wb_data[31:0], 32'hC0DE0100);

      // Reset asserted during FILL abandons the transfer and invalidates everything
      apply_reset();
      access(1, 0, 32'h120, 0, 0, rdata, fills, wbs, wb_addr, wb_data);
      check("rstfill_pre_fill", fills, 1);
      check("rstfill_pre_tag", dut.datapath.tag_array0.data[1], 24'h1);
      bus.mem_read = 1'b1;
      bus.mem_address = 32'h000;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = bus.pmem_read;
      end
      check("rstfill_fill_seen", seen, 1);
      rst_n = 1'b0;
      #1;
      check("rstfill_pmem_read_drop", bus.pmem_read, 0);
      check("rstfill_mem_resp", bus.mem_resp, 0);
      check("rstfill_tag_clear", dut.datapath.tag_array0.data[1], 0);
      @(posedge clk);
      #1;
      idle_inputs();
      rst_n = 1'b1;
      mem_m.delete();
      ref_m.delete();
      access(1, 0, 32'h120, 0, 0, rdata, fills, wbs, wb_addr, wb_data);
      check("rstfill_refill_120", fills, 1);
      access(1, 0, 32'h000, 0, 0, rdata, fills, wbs, wb_addr, wb_data);
      check("rstfill_refill_000", fills, 1);
      check("rstfill_rdata", rdata, 32'hC0DE0000);

      // Randomized accesses against the reference model
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         cnt[i] = 0;
         mru_t[i] = '0;
         lru_t[i] = '0;
      end
      for (int n = 0; n < 300; n++) begin
         tag = 24'($urandom_range(0, 3));
         s = 3'($urandom_range(0, 7));
         addr = {tag, s, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         op = $urandom_range(0, 3);
         rd = (op != 2);
         wr = (op >= 2);
         be = 4'($urandom_range(0, 15));
         wd = $urandom;
         exp_rdata = ref_rd(addr);
         exp_hit = (cnt[s] > 0 && mru_t[s] == tag) || (cnt[s] > 1 && lru_t[s] == tag);
         exp_wb = 1'b0;
         exp_wb_addr = '0;
         exp_wb_data = '0;
         if (exp_hit) begin
            if (cnt[s] > 1 && lru_t[s] == tag) begin
               lru_t[s] = mru_t[s];
               mru_t[s] = tag;
            end
         end else if (cnt[s] == 2) begin
            victim = lru_t[s];
            if (dirty_m.exists({victim, s})) begin
               exp_wb = 1'b1;
               exp_wb_addr = {victim, s, 5'b0};
               for (int k = 0; k < 8; k++) exp_wb_data[32*k +: 32] = ref_rd({victim, s, 3'(k), 2'b00});
               dirty_m.delete({victim, s});
            end
            lru_t[s] = mru_t[s];
            mru_t[s] = tag;
         end else begin
            lru_t[s] = mru_t[s];
            mru_t[s] = tag;
            cnt[s]++;
         end
         access(rd, wr, addr, wd, be, rdata, fills, wbs, wb_addr, wb_data);
         check($sformatf("rnd%0d_fills", n), fills, exp_hit ? 0 : 1);
         check($sformatf("rnd%0d_wbs", n), wbs, exp_wb ? 1 : 0);
         if (exp_wb) begin
            check($sformatf("rnd%0d_wb_addr", n), wb_addr, exp_wb_addr);
            check($sformatf("rnd%0d_wb_data", n), wb_data, exp_wb_data);
         end
         if (!wr) check($sformatf("rnd%0d_rdata", n), rdata, exp_rdata);
         if (wr) begin
            ref_wr(addr, wd, be);
            dirty_m[{tag, s}] = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
